ibuf_a_fifo: RTL
================

// Module: ibuf_a_fifo
// PURPOSE
//  Parametrised input buffer for one mesh-router input channel: a DEPTH-entry payload FIFO
//  (qos/type/src_pos/data) feeding NPORT output arbiters. Generalises single-entry buffering
//  to multi-entry storage and adds copy (multicast) delivery: in cpy_mode the head entry
//  stays until every requested output has taken it. Sits between link input and switch arbiters.
// PARAMETERS
//  PYLD_W  17  payload width (bits)
//  DEPTH   4   FIFO entries, >=1, any integer (pointers wrap at DEPTH-1)
//  NPORT   5   number of output ports / arbiters
//  CNT_W   $clog2(DEPTH+1)  occupancy counter width (derived, not overridden)
// PORTS
//  clk         in   1       clock; single clock domain
//  rst_n       in   1       asynchronous active-low reset
//  ibuf_vld    in   1       upstream payload valid
//  ibuf_rdy    out  1       buffer can accept; push = ibuf_vld & ibuf_rdy
//  payload_i   in   PYLD_W  upstream payload
//  pg_en       in   1       fault (bad node) present in path
//  cpy_mode    in   1       copy delivery required for head entry
//  arb_req     in   NPORT   output ports requested by head entry (from route compute)
//  arb_gnt     in   NPORT   per-port grant from output arbiters
//  obuf_rdy    in   NPORT   per-port downstream output buffer ready
//  head_vld    out  1       FIFO non-empty; payload_o valid
//  payload_o   out  PYLD_W  head entry payload
//  done_mask   out  NPORT   ports already served for current head (copy progress)
//  ibuf_cnt    out  CNT_W   current occupancy
// BEHAVIOUR
//  Reset: ptrs=0, ibuf_cnt=0, done_mask=0, storage=0 -> head_vld=0, payload_o=0, ibuf_rdy=1.
//  ibuf_rdy = (ibuf_cnt != DEPTH) & ~(pg_en & cpy_mode); from registers/inputs only, no pop
//   credit in same cycle (full + pop -> ibuf_rdy still 0 that cycle).
//  Push: write payload_i at wr_ptr; visible on payload_o earliest next cycle (no bypass).
//  sent = arb_req & arb_gnt & obuf_rdy & {NPORT{head_vld}}.
//  Normal (cpy_mode=0): pop when |sent. Single grant expected; multiple grants still one pop.
//  Copy (cpy_mode=1): acc = done_mask | sent; pop when arb_req!=0 and (acc & arb_req)==arb_req;
//   else done_mask <= acc. A port already in done_mask is not counted twice.
//  On any pop: rd_ptr advances (wrap), done_mask <= 0.
//  arb_req==0 never pops. Empty FIFO: sent forced 0, no pop, done_mask unchanged.
//  Simultaneous push+pop: ibuf_cnt unchanged, both ptrs advance; legal when not full.
//  cpy_mode falling mid-copy: next |sent pops normally; done_mask cleared on that pop.
//  pg_en&cpy_mode: inputs blocked; existing entries continue to drain per rules above.
//  Async reset mid-copy: all state returns to reset values immediately; partial copy dropped.
//  ibuf_cnt: +1 push, -1 pop, never exceeds DEPTH or underflows (push gated by ibuf_rdy).
// STRUCTURE
//  Shared package maze_pkg: NPORT default, port index constants (P_N,P_E,P_S,P_W,P_L),
//  payload field offsets (qos/type/src_pos/data).
//  Sub-module ibuf_copy_tracker (NPORT): computes sent, done_mask update and pop; FIFO
//  storage/pointers/counter remain in ibuf_a_fifo.
// TESTING
//  1 Reset: assert rst_n=0 mid-traffic -> head_vld=0, payload_o=0, ibuf_rdy=1, ibuf_cnt=0.
//  2 Fill: DEPTH=4, push 0x1,0x2,0x3,0x4 with no grants -> ibuf_cnt=4, ibuf_rdy=0, payload_o=0x1;
//    then arb_req=gnt=obuf_rdy=5'b00001 one cycle -> payload_o=0x2, ibuf_cnt=3, ibuf_rdy=1.
//  3 Copy: head 0xA, cpy_mode=1, arb_req=5'b10101; serve port0, then port2 (obuf_rdy[4]=0
//    stalls) -> done_mask=5'b00101, no pop; port4 served -> pop, done_mask=0.
//  4 Block: pg_en=1,cpy_mode=1, ibuf_vld=1 -> ibuf_rdy=0, no push; drain continues.
//  5 Simul push+pop at cnt=2 for 8 cycles with wrap -> cnt stays 2, order preserved.
//  6 Mode drop: cpy_mode 1->0 with done_mask=5'b00001 -> next grant on port2 pops, mask=0.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared mesh-router constants: port indices, payload field layout, pointer wrap helper
package maze_pkg;
    localparam int NPORT_DEF  = 5;
    localparam int PYLD_W_DEF = 17;

    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_S = 2;
    localparam int P_W = 3;
    localparam int P_L = 4;

    // payload = {qos[16], type[15:14], src_pos[13:8], data[7:0]}
    localparam int QOS_OFS  = 16;
    localparam int TYPE_OFS = 14;
    localparam int TYPE_W   = 2;
    localparam int SRC_OFS  = 8;
    localparam int SRC_W    = 6;
    localparam int DATA_OFS = 0;
    localparam int DATA_W   = 8;

    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/ibuf_a_fifo_if.sv
// rtl/ibuf_a_fifo_if.sv - link-input and arbiter-side signals of one router input buffer
interface ibuf_a_fifo_if #(
    parameter int PYLD_W = 17,
    parameter int DEPTH  = 4,
    parameter int NPORT  = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              ibuf_vld;
    logic              ibuf_rdy;
    logic [PYLD_W-1:0] payload_i;
    logic              pg_en;
    logic              cpy_mode;
    logic [NPORT-1:0]  arb_req;
    logic [NPORT-1:0]  arb_gnt;
    logic [NPORT-1:0]  obuf_rdy;
    logic              head_vld;
    logic [PYLD_W-1:0] payload_o;
    logic [NPORT-1:0]  done_mask;
    logic [CNT_W-1:0]  ibuf_cnt;

    modport master (
        output ibuf_vld, payload_i, pg_en, cpy_mode, arb_req, arb_gnt, obuf_rdy,
        input  ibuf_rdy, head_vld, payload_o, done_mask, ibuf_cnt
    );
    modport slave (
        input  ibuf_vld, payload_i, pg_en, cpy_mode, arb_req, arb_gnt, obuf_rdy,
        output ibuf_rdy, head_vld, payload_o, done_mask, ibuf_cnt
    );
endinterface

// File: rtl/ibuf_copy_tracker.sv
// rtl/ibuf_copy_tracker.sv - per-head delivery tracking: served ports, multicast progress, pop decision
module ibuf_copy_tracker #(
    parameter int NPORT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             head_vld,
    input  logic             cpy_mode,
    input  logic [NPORT-1:0] arb_req,
    input  logic [NPORT-1:0] arb_gnt,
    input  logic [NPORT-1:0] obuf_rdy,
    output logic             pop,
    output logic [NPORT-1:0] done_mask
);
    logic [NPORT-1:0] sent;
    logic [NPORT-1:0] acc;

    always_comb begin
        sent = arb_req & arb_gnt & obuf_rdy & {NPORT{head_vld}};
        acc  = done_mask | sent;
        // head_vld gate matters in copy mode: a stale mask must not pop an empty FIFO
        if (cpy_mode) begin
            pop = head_vld && (arb_req != '0) && ((acc & arb_req) == arb_req);
        end else begin
            pop = |sent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_mask <= '0;
        end else if (pop) begin
            done_mask <= '0;
        end else if (cpy_mode) begin
            done_mask <= acc;
        end
    end
endmodule

// File: rtl/ibuf_a_fifo.sv
// rtl/ibuf_a_fifo.sv - DEPTH-entry router input FIFO with normal and multicast (copy) head delivery
module ibuf_a_fifo
    import maze_pkg::*;
#(
    parameter int PYLD_W = PYLD_W_DEF,
    parameter int DEPTH  = 4,
    parameter int NPORT  = NPORT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    ibuf_a_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PYLD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;

    assign bus.ibuf_rdy  = (cnt != CNT_W'(DEPTH)) && !(bus.pg_en && bus.cpy_mode);
    assign push          = bus.ibuf_vld && bus.ibuf_rdy;
    assign bus.head_vld  = (cnt != '0);
    assign bus.payload_o = mem[rd_ptr];
    assign bus.ibuf_cnt  = cnt;

    ibuf_copy_tracker #(.NPORT(NPORT)) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .head_vld  (bus.head_vld),
        .cpy_mode  (bus.cpy_mode),
        .arb_req   (bus.arb_req),
        .arb_gnt   (bus.arb_gnt),
        .obuf_rdy  (bus.obuf_rdy),
        .pop       (pop),
        .done_mask (bus.done_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.payload_i;
                wr_ptr      <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule
